apb_slave_regfile: RTL and testbench

APB completer that sits directly downstream of the team's APB requester. It terminates one PSEL line and backs it with a bank of byte-writable 32-bit registers. A programmable wait-state counter holds off PREADY, and the block returns read data and, optionally, an error response. Two instances with different BASE_ADDR serve the requester's two select lines.

---
 rtl/apb_slave_regfile.sv | 109 ++++++++++
 tb/tb_apb_slave_regfile.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regfile.sv
// APB completer backed by NUM_REGS byte-writable 32-bit registers with programmable wait states.
// Optional macro APB_SLV_PSLVERR_EN: report decode errors on PSLVERR (otherwise tied low).
module apb_slave_regfile #(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter int                NUM_REGS    = 16,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [3:0]        PSTRB,
    output logic              PREADY,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PSLVERR
);

    localparam int                IDX_W      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    // Handshake: a transfer completes on the edge where PSEL & PENABLE & PREADY are all high.
    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state, state_nxt;
    logic [3:0]          cnt;
    logic [IDX_W-1:0]    idx_q;
    logic                write_q;
    logic                err_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [3:0]          strb_q;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [ADDR_W-1:0]   offset;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_err;
    logic                setup;
    logic                xfer_on;
    logic                ready_int;

    always_comb begin
        offset  = PADDR - BASE_ADDR;
        dec_idx = offset[IDX_W+1:2];
        dec_err = (PADDR < BASE_ADDR) || (offset[1:0] != 2'b00) || ((offset >> 2) >= NUM_REGS_A);
    end

    assign setup     = (state == IDLE) && PSEL && !PENABLE;
    assign xfer_on   = PSEL && PENABLE;
    // Only PSEL/PENABLE reach PREADY combinationally; the rest is registered state.
    assign ready_int = (state == ACCESS) && xfer_on && (cnt == 4'd0);

    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (setup) state_nxt = ACCESS;
            ACCESS:  if (!xfer_on || cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        PREADY = ready_int;
`ifdef APB_SLV_PSLVERR_EN
        PSLVERR = ready_int && err_q;
`else
        PSLVERR = 1'b0;
`endif
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt     <= 4'd0;
            idx_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= 4'd0;
            PRDATA  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (setup) begin
                idx_q   <= dec_idx;
                write_q <= PWRITE;
                err_q   <= dec_err;
                wdata_q <= PWDATA;
                strb_q  <= PSTRB;
                cnt     <= 4'(WAIT_CYCLES);
                PRDATA  <= (dec_err || PWRITE) ? '0 : regs[dec_idx];
            end else if ((state == ACCESS) && xfer_on && (cnt != 4'd0)) begin
                cnt <= cnt - 4'd1;
            end
            // Erroneous writes are dropped whether or not PSLVERR is reported.
            if (ready_int && write_q && !err_q) begin
                for (int i = 0; i < 4; i++)
                    if (strb_q[i]) regs[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two instances (2 wait states / base 0 / 16 regs, and
// 0 wait states / base 0x1000 / 5 regs) driven by directed and random APB transfers.
module tb_apb_slave_regfile;

`ifdef APB_SLV_PSLVERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [31:0] BASE0 = 32'h0;
    localparam logic [31:0] BASE1 = 32'h1000;

    logic        clk;
    logic        preset  [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [31:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];

    logic [31:0] model [2][256];
    logic [31:0] exp_q [$];
    int total = 0;
    int bad   = 0;

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(2), .BASE_ADDR(BASE0)) u_dut0 (
        .PCLK(clk), .PRESET(preset[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
        .PWRITE(pwrite[0]), .PADDR(paddr[0]), .PWDATA(pwdata[0]), .PSTRB(pstrb[0]),
        .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0])
    );

    apb_slave_regfile #(.NUM_REGS(5), .WAIT_CYCLES(0), .BASE_ADDR(BASE1)) u_dut1 (
        .PCLK(clk), .PRESET(preset[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
        .PWRITE(pwrite[1]), .PADDR(paddr[1]), .PWDATA(pwdata[1]), .PSTRB(pstrb[1]),
        .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1])
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int nregs_of(input int d);
        return (d == 0) ? 16 : 5;
    endfunction

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic bit addr_err(input int d, input logic [31:0] a);
        logic [31:0] off;
        if (a < base_of(d)) return 1'b1;
        off = a - base_of(d);
        if (off % 4 != 0) return 1'b1;
        if (off / 4 >= 32'(nregs_of(d))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_idle(input int d);
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 with the bus idle (the caller may start
    // another setup immediately for back-to-back). abort_k / rst_k select the access
    // cycle in which PSEL is dropped or PRESET is asserted (0 = never).
    task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] sb, input int abort_k, input int rst_k);
        bit          err;
        bit          done;
        int          lo;
        logic [31:0] exp_rd;
        err    = addr_err(d, a);
        exp_rd = (wr || err) ? 32'h0 : model[d][(a - base_of(d)) >> 2];
        exp_q.push_back(exp_rd);
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
        paddr[d] = a; pwdata[d] = wd; pstrb[d] = sb;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        // Setup values must be ignored once in the access phase.
        paddr[d] = $urandom; pwdata[d] = $urandom; pstrb[d] = 4'($urandom_range(0, 15)); pwrite[d] = ~wr;
        lo = 0;
        done = 1'b0;
        for (int k = 1; k <= 20 && !done; k++) begin
            if (k == abort_k) psel[d] = 1'b0;
            if (k == rst_k) preset[d] = 1'b1;
            @(negedge clk);
            if (k == abort_k || k == rst_k) begin
                done = 1'b1;
                void'(exp_q.pop_front());
                @(posedge clk); #1;
                preset[d] = 1'b0;
                bus_idle(d);
                if (k == rst_k)
                    for (int i = 0; i < 256; i++) model[d][i] = 32'h0;
                @(negedge clk);
                check_eq("abort_ready", 32'(pready[d]), 32'h0);
                if (k == rst_k) check_eq("midrst_prdata", prdata[d], 32'h0);
                @(posedge clk); #1;
            end else if (pready[d]) begin
                done = 1'b1;
                check_eq("latency", 32'(lo), 32'(wait_of(d)));
                check_eq("prdata", prdata[d], exp_q.pop_front());
                check_eq("pslverr", 32'(pslverr[d]), 32'(ERR_EN && err));
                if (wr && !err)
                    for (int i = 0; i < 4; i++)
                        if (sb[i]) model[d][(a - base_of(d)) >> 2][8*i +: 8] = wd[8*i +: 8];
                @(posedge clk); #1;
                bus_idle(d);
            end else begin
                lo++;
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            check_eq("timeout", 32'(lo), 32'(wait_of(d)));
            void'(exp_q.pop_front());
            bus_idle(d);
        end
    endtask

    task automatic scan(input int d);
        for (int i = 0; i < nregs_of(d); i++) begin
            xfer(d, 1'b0, base_of(d) + 32'(4 * i), 32'h0, 4'h0, 0, 0);
            idle_cycles(1);
        end
    endtask

    task automatic rand_xfer(input int d);
        int          r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        if (r < 7)       a = base_of(d) + 32'(4 * $urandom_range(0, nregs_of(d) - 1));
        else if (r == 7) a = base_of(d) + 32'(4 * $urandom_range(0, nregs_of(d) - 1)) + 32'($urandom_range(1, 3));
        else if (r == 8) a = base_of(d) + 32'(4 * (nregs_of(d) + $urandom_range(0, 10)));
        else if (d == 1) a = 32'($urandom_range(0, 32'hFFF));
        else             a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        xfer(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 0, 0);
        if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            preset[d] = 1'b1; pwrite[d] = 1'b0; paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0;
            bus_idle(d);
            for (int i = 0; i < 256; i++) model[d][i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        preset[0] = 1'b0;
        preset[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq("rst_pready", 32'(pready[d]), 32'h0);
            check_eq("rst_prdata", prdata[d], 32'h0);
            check_eq("rst_pslverr", 32'(pslverr[d]), 32'h0);
        end
        @(posedge clk); #1;

        xfer(0, 1'b0, 32'd12, 32'h0, 4'h0, 0, 0);
        check_eq("rst_reg3", prdata[0], 32'h0);
        idle_cycles(1);
        xfer(0, 1'b1, 32'd8, 32'hDEADBEEF, 4'hF, 0, 0);
        idle_cycles(1);
        xfer(0, 1'b0, 32'd8, 32'h0, 4'h0, 0, 0);
        check_eq("rd8_full", prdata[0], 32'hDEADBEEF);
        idle_cycles(2);
        check_eq("prdata_hold", prdata[0], 32'hDEADBEEF);
        xfer(0, 1'b1, 32'd8, 32'h11223344, 4'b0101, 0, 0);
        idle_cycles(1);
        xfer(0, 1'b0, 32'd8, 32'h0, 4'h0, 0, 0);
        check_eq("rd8_strb", prdata[0], 32'hDE22BE44);
        idle_cycles(1);
        xfer(0, 1'b1, 32'd8, 32'hFFFFFFFF, 4'b0000, 0, 0);
        idle_cycles(1);
        xfer(0, 1'b0, 32'd8, 32'h0, 4'h0, 0, 0);
        check_eq("rd8_strb0", prdata[0], 32'hDE22BE44);
        idle_cycles(1);
        xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 0, 0);
        idle_cycles(1);
        xfer(0, 1'b0, 32'h42, 32'h0, 4'h0, 0, 0);
        check_eq("rd_err_zero", prdata[0], 32'h0);
        idle_cycles(1);
        xfer(0, 1'b1, 32'd8, 32'h55AA55AA, 4'hF, 2, 0);
        xfer(0, 1'b0, 32'd8, 32'h0, 4'h0, 0, 0);
        check_eq("rd8_after_abort", prdata[0], 32'hDE22BE44);
        idle_cycles(1);

        xfer(1, 1'b1, BASE1 + 32'd4, 32'hCAFEF00D, 4'hF, 0, 0);
        xfer(1, 1'b0, BASE1 + 32'd4, 32'h0, 4'h0, 0, 0);
        check_eq("b2b_read", prdata[1], 32'hCAFEF00D);
        xfer(1, 1'b0, BASE1 + 32'h10, 32'h0, 4'h0, 0, 0);
        xfer(1, 1'b1, BASE1 + 32'h14, 32'h1, 4'hF, 0, 0);
        xfer(1, 1'b0, BASE1 - 32'd4, 32'h0, 4'h0, 0, 0);
        idle_cycles(1);

        for (int n = 0; n < 80; n++) begin
            rand_xfer(0);
            rand_xfer(1);
        end
        idle_cycles(1);
        scan(0);
        scan(1);

        xfer(0, 1'b1, 32'd4, 32'hA5A5A5A5, 4'hF, 0, 1);
        scan(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
